// File: rtl/register_bank_tristate.sv
// register_bank_tristate
//   Small bank of NrOfRegs registers, NrOfBits wide. One register (WAddr) may be
//   loaded, incremented or shifted per qualified clock edge; any register can be
//   read combinationally onto a tri-state bus.
//
// Ports
//   Clock       capture clock (edge chosen by ActiveLevel: 1 rising, 0 falling)
//   Reset       async, active-high; clears all registers and Carry (wins over pre)
//   pre         async, active-high; sets all registers to all-ones, clears Carry
//   ClockEnable global update enable
//   Tick        update qualifier; update only when ClockEnable & Tick
//   Op          00 hold, 01 load D, 10 increment, 11 shift-left inserting D[0]
//   WAddr       register targeted by Op
//   D           load / shift-in data
//   RAddr       read select
//   cs          active-low output enable; 1 drives Q to Z
//   Q           read data (tri-state)
//   Carry       carry / shift-out of the last executed non-hold Op
module register_bank_tristate #(
  parameter int NrOfBits    = 8,
  parameter int NrOfRegs    = 4,
  parameter int AddrBits    = 2,
  parameter int ActiveLevel = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic [1:0]          Op,
  input  logic [AddrBits-1:0] WAddr,
  input  logic [NrOfBits-1:0] D,
  input  logic [AddrBits-1:0] RAddr,
  input  logic                cs,
  output logic [NrOfBits-1:0] Q,
  output logic                Carry
);

  logic [NrOfBits-1:0] regs [NrOfRegs];
  logic [NrOfBits-1:0] cur_val;
  logic [NrOfBits-1:0] nxt_val;
  logic                nxt_carry;
  logic                update;

  assign cur_val = regs[WAddr];

  // A hold Op is treated like "no update" so that Carry keeps the result of the
  // last real operation.
  assign update = ClockEnable & Tick & (Op != 2'b00);

  always_comb begin
    nxt_val   = cur_val;
    nxt_carry = Carry;
    case (Op)
      2'b01: begin
        nxt_val   = D;
        nxt_carry = 1'b0;
      end
      2'b10: begin
        {nxt_carry, nxt_val} = {1'b0, cur_val} + {{NrOfBits{1'b0}}, 1'b1};
      end
      2'b11: begin
        // Shift form works for NrOfBits == 1 as well: the shifted value is 0,
        // so the register simply takes D[0].
        nxt_val   = (cur_val << 1) | {{(NrOfBits-1){1'b0}}, D[0]};
        nxt_carry = cur_val[NrOfBits-1];
      end
      default: begin
        nxt_val   = cur_val;
        nxt_carry = Carry;
      end
    endcase
  end

  generate
    if (ActiveLevel != 0) begin : g_rise
      always_ff @(posedge Clock or posedge Reset or posedge pre) begin
        if (Reset) begin
          for (int i = 0; i < NrOfRegs; i++) regs[i] <= '0;
          Carry <= 1'b0;
        end else if (pre) begin
          for (int i = 0; i < NrOfRegs; i++) regs[i] <= '1;
          Carry <= 1'b0;
        end else if (update) begin
          regs[WAddr] <= nxt_val;
          Carry       <= nxt_carry;
        end
      end
    end else begin : g_fall
      always_ff @(negedge Clock or posedge Reset or posedge pre) begin
        if (Reset) begin
          for (int i = 0; i < NrOfRegs; i++) regs[i] <= '0;
          Carry <= 1'b0;
        end else if (pre) begin
          for (int i = 0; i < NrOfRegs; i++) regs[i] <= '1;
          Carry <= 1'b0;
        end else if (update) begin
          regs[WAddr] <= nxt_val;
          Carry       <= nxt_carry;
        end
      end
    end
  endgenerate

  // No write bypass: Q shows the stored value, so a same-cycle write to RAddr
  // appears only after the active edge.
  assign Q = cs ? {NrOfBits{1'bz}} : regs[RAddr];

endmodule

// File: tb/tb_register_bank_tristate.sv
module tb_register_bank_tristate;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pre, ce, ce_n, tick, cs;
  logic [1:0] op, wa, ra;
  logic [7:0] d;
  tri1  [7:0] q, q_n;
  logic       c, c_n;

  register_bank_tristate #(.NrOfBits(8), .NrOfRegs(4), .AddrBits(2), .ActiveLevel(1)) dut (
    .Clock(clk), .Reset(rst), .pre(pre), .ClockEnable(ce), .Tick(tick), .Op(op),
    .WAddr(wa), .D(d), .RAddr(ra), .cs(cs), .Q(q), .Carry(c)
  );

  register_bank_tristate #(.NrOfBits(8), .NrOfRegs(4), .AddrBits(2), .ActiveLevel(0)) dut_n (
    .Clock(clk), .Reset(rst), .pre(pre), .ClockEnable(ce_n), .Tick(tick), .Op(op),
    .WAddr(wa), .D(d), .RAddr(ra), .cs(cs), .Q(q_n), .Carry(c_n)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       ce;
    logic       tick;
    logic [1:0] op;
    logic [1:0] wa;
    logic [1:0] ra;
    logic [7:0] d;
    logic [7:0] eq;
    logic       ec;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       c;
  } exp_t;

  localparam int NV = 19;
  vec_t vt [NV];
  exp_t sbq [$];

  function automatic vec_t mk(input logic ce_i, input logic tick_i, input logic [1:0] op_i,
                              input logic [1:0] wa_i, input logic [1:0] ra_i, input logic [7:0] d_i,
                              input logic [7:0] eq_i, input logic ec_i);
    vec_t v;
    v.ce = ce_i; v.tick = tick_i; v.op = op_i; v.wa = wa_i;
    v.ra = ra_i; v.d = d_i; v.eq = eq_i; v.ec = ec_i;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    //          ce tick op     wa     ra     d      exp_q  exp_c
    vt[0]  = mk(1, 1, 2'b01, 2'd2, 2'd2, 8'hA5, 8'hA5, 1'b0);
    vt[1]  = mk(1, 1, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
    vt[2]  = mk(1, 1, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0);
    vt[3]  = mk(1, 1, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0);
    vt[4]  = mk(1, 1, 2'b01, 2'd1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    vt[5]  = mk(1, 1, 2'b10, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1);
    vt[6]  = mk(1, 1, 2'b10, 2'd1, 2'd1, 8'h00, 8'h01, 1'b0);
    vt[7]  = mk(1, 1, 2'b01, 2'd0, 2'd0, 8'h81, 8'h81, 1'b0);
    vt[8]  = mk(1, 1, 2'b11, 2'd0, 2'd0, 8'h00, 8'h02, 1'b1);
    vt[9]  = mk(1, 0, 2'b11, 2'd0, 2'd0, 8'h01, 8'h02, 1'b1);
    vt[10] = mk(0, 1, 2'b11, 2'd0, 2'd0, 8'h01, 8'h02, 1'b1);
    vt[11] = mk(1, 1, 2'b11, 2'd0, 2'd0, 8'h01, 8'h05, 1'b0);
    vt[12] = mk(1, 1, 2'b10, 2'd3, 2'd2, 8'h00, 8'hA5, 1'b0);
    vt[13] = mk(1, 1, 2'b00, 2'd3, 2'd3, 8'h00, 8'h01, 1'b0);
    vt[14] = mk(1, 1, 2'b01, 2'd3, 2'd3, 8'h80, 8'h80, 1'b0);
    vt[15] = mk(1, 1, 2'b11, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1);
    vt[16] = mk(1, 1, 2'b00, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1);
    vt[17] = mk(1, 1, 2'b01, 2'd2, 2'd2, 8'h7F, 8'h7F, 1'b0);
    vt[18] = mk(1, 1, 2'b10, 2'd2, 2'd2, 8'h00, 8'h80, 1'b0);

    rst = 1'b0; pre = 1'b0; ce = 1'b0; ce_n = 1'b0; tick = 1'b0; cs = 1'b0;
    op = 2'b00; wa = 2'd0; ra = 2'd0; d = 8'h00;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1 check($sformatf("reset_q%0d", i), q, 8'h00);
    end
    check("reset_carry", c, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Falling-edge instance: rising edge must not capture.
    @(negedge clk); #1;
    ce_n = 1'b1; tick = 1'b1; op = 2'b01; wa = 2'd0; d = 8'h3C; ra = 2'd0;
    @(posedge clk); #1;
    check("fall_rise_nochange", q_n, 8'h00);
    @(negedge clk); #1;
    check("fall_captured", q_n, 8'h3C);
    check("fall_rise_inst_idle", q, 8'h00);
    ce_n = 1'b0; op = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      ce = vt[i].ce; tick = vt[i].tick; op = vt[i].op;
      wa = vt[i].wa; ra = vt[i].ra; d = vt[i].d;
      sbq.push_back('{q: vt[i].eq, c: vt[i].ec});
      @(posedge clk); #1;
      e = sbq.pop_front();
      check($sformatf("vec%0d_q", i), q, e.q);
      check($sformatf("vec%0d_carry", i), c, e.c);
    end

    // Same-cycle read of the write target shows the old value until the edge.
    ce = 1'b1; tick = 1'b1; op = 2'b01; wa = 2'd2; ra = 2'd2; d = 8'h11;
    #1 check("nobypass_old", q, 8'h80);
    @(posedge clk); #1;
    check("nobypass_new", q, 8'h11);

    // Get Carry to 1 so the preset visibly clears it.
    op = 2'b01; wa = 2'd3; d = 8'hFF;
    @(posedge clk); #1;
    op = 2'b10;
    @(posedge clk); #1;
    check("carry_setup", c, 1'b1);
    op = 2'b00;

    @(negedge clk); #1;
    pre = 1'b1;
    #1 check("pre_carry", c, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1 check($sformatf("pre_q%0d", i), q, 8'hFF);
    end
    op = 2'b01; wa = 2'd0; d = 8'h12; ra = 2'd0;
    @(posedge clk); #1;
    check("pre_edge_ignored", q, 8'hFF);
    pre = 1'b0;
    @(posedge clk); #1;
    check("after_pre_release", q, 8'h12);
    op = 2'b00;

    @(negedge clk); #1;
    pre = 1'b1;
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1 check($sformatf("rst_pre_q%0d", i), q, 8'h00);
    end
    check("rst_pre_carry", c, 1'b0);
    rst = 1'b0; pre = 1'b0;

    // Output disabled: bus floats, but updates still happen.
    cs = 1'b1; op = 2'b01; wa = 2'd0; d = 8'hA5; ra = 2'd0;
    @(posedge clk); #1;
    check("cs_hiz", ((q === 8'hzz) || (q === 8'hFF)), 1'b1);
    cs = 1'b0; op = 2'b00;
    #1 check("cs_update_done", q, 8'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
